tawas_slice_sched: RTL and testbench
====================================

TAWAS_SLICE_SCHED -- requirements
Module: tawas_slice_sched

Interface
REQ-001 Parameter RESET_RUN_MASK, default 4'b0001, selects the threads that are in RUN after reset.
REQ-002 Parameter WAIT_TIMEOUT, default 8'd255, is the WAIT-state timeout in rotations.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 slice  output  2  current issue slot; thread N issues in slice N.
REQ-006 thread_vld  output  1  high when the thread owning the current slice is in RUN; gates au_op_vld and fetch.
REQ-007 wait_req  input  1  request to place thread wait_thread in WAIT (bus access outstanding).
REQ-008 wait_thread  input  2  thread index for wait_req.
REQ-009 wait_done  input  4  per-thread resume bitmask.
REQ-010 halt_req  input  1  request to place thread halt_thread in HALT.
REQ-011 halt_thread  input  2  thread index for halt_req.
REQ-012 start_req  input  1  software start strobe.
REQ-013 start_mask  input  4  threads to start on start_req.
REQ-014 irq  input  4  per-thread level interrupt; wakes a HALT thread.
REQ-015 thread_state  output  8  2-bit state per thread; thread N uses bits [2N+1:2N].
REQ-016 idle  output  1  high when all four threads are in HALT.
REQ-017 wake_vld  output  1  one-cycle pulse on any HALT->RUN transition.
REQ-018 wake_thread  output  2  thread index of the wake_vld event.
REQ-019 wake_irq  output  1  high when the wake_vld event was caused by irq.
REQ-020 timeout_err  output  4  sticky per-thread WAIT timeout flag.

Function
REQ-021 slice SHALL increment by 1 every clk and wrap 3->0.
REQ-022 Each thread SHALL hold one state: HALT, RUN or WAIT.
REQ-023 thread_vld SHALL equal (state[slice]==RUN), decoded combinationally from registered state.
REQ-024 RUN->WAIT SHALL occur on wait_req for that thread; the new state is visible next cycle.
REQ-025 WAIT->RUN SHALL occur on wait_done[t]; wait_done for a thread not in WAIT is ignored.
REQ-026 If wait_done[t] and wait_req for t occur in the same cycle on a WAIT thread, the thread SHALL stay in WAIT and its timeout counter SHALL reset.
REQ-027 Any state ->HALT SHALL occur on halt_req for that thread; halt_req takes priority over wait_req, wait_done, start_req and irq.
REQ-028 HALT->RUN SHALL occur on start_req with start_mask[t]=1, or on irq[t]=1.
REQ-029 start_req or irq on a thread in RUN or WAIT SHALL have no effect; irq remains level-pending.
REQ-030 wake_vld SHALL be registered, asserted the cycle after a HALT->RUN transition.
REQ-031 When several threads wake in the same cycle, wake_vld SHALL report the lowest index; the others SHALL be reported in the following cycles in ascending order, with at most one report pending per thread.
REQ-032 wake_irq SHALL be 1 when irq[t] caused the transition, including when start_req coincides with it.
REQ-033 Each thread SHALL have an 8-bit timeout counter, cleared on entry to WAIT and incremented when slice==t and the thread is in WAIT.
REQ-034 When the counter reaches WAIT_TIMEOUT, the thread SHALL move to HALT and timeout_err[t] SHALL be set; wait_done in that same cycle takes priority and the thread resumes.
REQ-035 timeout_err[t] SHALL be cleared only by a start_req that starts thread t.
REQ-036 idle SHALL be decoded combinationally from registered state.

Reset
REQ-037 On rst: slice=0; state[t]=RUN where RESET_RUN_MASK[t]=1, else HALT; all counters=0; timeout_err=0; wake_vld=0; wake_thread=0; wake_irq=0; no wake reports pending.
REQ-038 rst asserted mid-WAIT SHALL discard the WAIT state and the timeout count, with no wake pulse on release.

Structure
REQ-039 Package tawas_sched_pkg SHALL define the state encoding (HALT=2'b00, RUN=2'b01, WAIT=2'b10) and the counter width constant.
REQ-040 Sub-module tawas_sched_thread SHALL implement one thread's FSM, timeout counter and error flag, and SHALL be instantiated four times.
REQ-041 The slice counter, wake queue and output decode SHALL reside in the top level.

Verification
REQ-042 Release reset with default parameters -> slice cycles 0,1,2,3,0; thread_vld=1 only in slice 0; idle=0.
REQ-043 wait_req with thread 0, then wait_done=4'b0001 after 10 cycles -> thread_state[1:0]=WAIT until resume; thread_vld=0 in slice 0 during WAIT; no timeout_err.
REQ-044 Set WAIT_TIMEOUT=3, wait_req for thread 0, never assert wait_done -> HALT after the 3rd slice-0 rotation; timeout_err=4'b0001; start_req with start_mask=4'b0001 clears the flag and restores RUN.
REQ-045 Halt all threads, then irq=4'b1010 -> wake_vld on two consecutive cycles with wake_thread=1 then 3 and wake_irq=1; idle falls.
REQ-046 Same cycle: halt_req and wait_req both for thread 2, which is in RUN -> thread 2 goes to HALT.
REQ-047 start_req with start_mask=4'b0100 and irq[2]=1 on halted thread 2 -> single wake_vld, wake_thread=2, wake_irq=1.

Source files
------------

// File: rtl/tawas_sched_pkg.sv
// Shared encodings and sizing for the Tawas slice scheduler.
package tawas_sched_pkg;

    localparam int NUM_THREADS = 4;
    localparam int TID_W       = 2;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [TID_W-1:0] lowest_idx(input logic [NUM_THREADS-1:0] m);
        logic [TID_W-1:0] r;
        r = '0;
        for (int i = NUM_THREADS - 1; i >= 0; i--) begin
            if (m[i]) r = TID_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/tawas_sched_thread.sv
// One hardware thread: HALT/RUN/WAIT state, WAIT timeout counter, sticky error.
//
// state   | meaning
// --------+-------------------------------------------------------
// ST_HALT | not scheduled; leaves on start strobe or irq
// ST_RUN  | issues in its slice
// ST_WAIT | bus access outstanding; counts its own slices until
//         | wait_done or timeout
module tawas_sched_thread
    import tawas_sched_pkg::*;
#(
    parameter logic             RESET_RUN    = 1'b0,
    parameter logic [CNT_W-1:0] WAIT_TIMEOUT = 8'd255
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   slice_hit_i,
    input  logic   wait_req_i,
    input  logic   wait_done_i,
    input  logic   halt_req_i,
    input  logic   start_i,
    input  logic   irq_i,
    output state_t state_o,
    output logic   timeout_err_o,
    output logic   wake_o,
    output logic   wake_irq_o
);

    localparam state_t RESET_STATE = RESET_RUN ? ST_RUN : ST_HALT;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Next-state: halt wins over everything; the counter is zero outside WAIT.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        wake_o     = 1'b0;
        wake_irq_o = 1'b0;
        if (halt_req_i) begin
            state_d = ST_HALT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_HALT: begin
                    if (start_i || irq_i) begin
                        state_d    = ST_RUN;
                        wake_o     = 1'b1;
                        wake_irq_o = irq_i;
                        if (start_i) err_d = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (wait_req_i) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT: begin
                    if (wait_done_i && wait_req_i) begin
                        cnt_d = '0;
                    end else if (wait_done_i) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else if (cnt_q == WAIT_TIMEOUT) begin
                        state_d = ST_HALT;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                    end else if (slice_hit_i) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign state_o       = state_q;
    assign timeout_err_o = err_q;

endmodule

// File: rtl/tawas_slice_sched.sv
// Four-thread barrel scheduler: slice rotation, per-thread FSMs, wake reporting.
module tawas_slice_sched
    import tawas_sched_pkg::*;
#(
    parameter logic [NUM_THREADS-1:0] RESET_RUN_MASK = 4'b0001,
    parameter logic [CNT_W-1:0]       WAIT_TIMEOUT   = 8'd255
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [TID_W-1:0]         slice,
    output logic                     thread_vld,
    input  logic                     wait_req,
    input  logic [TID_W-1:0]         wait_thread,
    input  logic [NUM_THREADS-1:0]   wait_done,
    input  logic                     halt_req,
    input  logic [TID_W-1:0]         halt_thread,
    input  logic                     start_req,
    input  logic [NUM_THREADS-1:0]   start_mask,
    input  logic [NUM_THREADS-1:0]   irq,
    output logic [2*NUM_THREADS-1:0] thread_state,
    output logic                     idle,
    output logic                     wake_vld,
    output logic [TID_W-1:0]         wake_thread,
    output logic                     wake_irq,
    output logic [NUM_THREADS-1:0]   timeout_err
);

    logic [TID_W-1:0]       slice_q;
    state_t                 st [NUM_THREADS];
    logic [NUM_THREADS-1:0] wake_now, wake_irq_now;

    // Wake reports not yet emitted, with their irq cause.
    logic [NUM_THREADS-1:0] pend_q, pend_d, pend_irq_q, pend_irq_d;
    logic                   wake_vld_q, wake_vld_d, wake_irq_q, wake_irq_d;
    logic [TID_W-1:0]       wake_thread_q, wake_thread_d;

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
        tawas_sched_thread #(
            .RESET_RUN    (RESET_RUN_MASK[t]),
            .WAIT_TIMEOUT (WAIT_TIMEOUT)
        ) u_thr (
            .clk           (clk),
            .rst           (rst),
            .slice_hit_i   (slice_q == TID_W'(t)),
            .wait_req_i    (wait_req && (wait_thread == TID_W'(t))),
            .wait_done_i   (wait_done[t]),
            .halt_req_i    (halt_req && (halt_thread == TID_W'(t))),
            .start_i       (start_req && start_mask[t]),
            .irq_i         (irq[t]),
            .state_o       (st[t]),
            .timeout_err_o (timeout_err[t]),
            .wake_o        (wake_now[t]),
            .wake_irq_o    (wake_irq_now[t])
        );
        assign thread_state[2*t +: 2] = st[t];
    end

    // Merge fresh wakes with pending ones and emit the lowest index first.
    always_comb begin
        logic [NUM_THREADS-1:0] cand;
        logic [TID_W-1:0]       pick;
        cand          = pend_q | wake_now;
        pend_irq_d    = (wake_now & wake_irq_now) | (~wake_now & pend_irq_q);
        pick          = lowest_idx(cand);
        pend_d        = cand;
        wake_vld_d    = |cand;
        wake_thread_d = '0;
        wake_irq_d    = 1'b0;
        if (|cand) begin
            pend_d[pick]  = 1'b0;
            wake_thread_d = pick;
            wake_irq_d    = pend_irq_d[pick];
        end
    end

    // Slice rotation and wake report registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slice_q       <= '0;
            pend_q        <= '0;
            pend_irq_q    <= '0;
            wake_vld_q    <= 1'b0;
            wake_thread_q <= '0;
            wake_irq_q    <= 1'b0;
        end else begin
            slice_q       <= slice_q + TID_W'(1);
            pend_q        <= pend_d;
            pend_irq_q    <= pend_irq_d;
            wake_vld_q    <= wake_vld_d;
            wake_thread_q <= wake_thread_d;
            wake_irq_q    <= wake_irq_d;
        end
    end

    // All threads halted.
    always_comb begin
        idle = 1'b1;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (st[i] != ST_HALT) idle = 1'b0;
        end
    end

    assign slice       = slice_q;
    assign thread_vld  = (st[slice_q] == ST_RUN);
    assign wake_vld    = wake_vld_q;
    assign wake_thread = wake_thread_q;
    assign wake_irq    = wake_irq_q;

endmodule

// File: tb/tb_tawas_slice_sched.sv
`define CHK(tag, obs, exp) chk(tag, 32'(obs), 32'(exp))

module tb_tawas_slice_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wait_req, halt_req, start_req;
   logic [1:0] wait_thread, halt_thread;
   logic [3:0] wait_done, start_mask, irq;

   logic [1:0] d_slice, d_wake_thread, t_slice, t_wake_thread;
   logic       d_thread_vld, d_idle, d_wake_vld, d_wake_irq;
   logic       t_thread_vld, t_idle, t_wake_vld, t_wake_irq;
   logic [7:0] d_thread_state, t_thread_state;
   logic [3:0] d_timeout_err, t_timeout_err;

   int         total = 0;
   int         bad   = 0;
   logic [1:0] exp_slice = 2'd0;

   always #5 clk = ~clk;

   tawas_slice_sched dut (
      .clk(clk), .rst(rst), .slice(d_slice), .thread_vld(d_thread_vld),
      .wait_req(wait_req), .wait_thread(wait_thread), .wait_done(wait_done),
      .halt_req(halt_req), .halt_thread(halt_thread), .start_req(start_req),
      .start_mask(start_mask), .irq(irq), .thread_state(d_thread_state),
      .idle(d_idle), .wake_vld(d_wake_vld), .wake_thread(d_wake_thread),
      .wake_irq(d_wake_irq), .timeout_err(d_timeout_err)
   );

   tawas_slice_sched #(.RESET_RUN_MASK(4'b0001), .WAIT_TIMEOUT(8'd3)) dut_to (
      .clk(clk), .rst(rst), .slice(t_slice), .thread_vld(t_thread_vld),
      .wait_req(wait_req), .wait_thread(wait_thread), .wait_done(wait_done),
      .halt_req(halt_req), .halt_thread(halt_thread), .start_req(start_req),
      .start_mask(start_mask), .irq(irq), .thread_state(t_thread_state),
      .idle(t_idle), .wake_vld(t_wake_vld), .wake_thread(t_wake_thread),
      .wake_irq(t_wake_irq), .timeout_err(t_timeout_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         total++;
         if (d_thread_vld !== (d_thread_state[2*d_slice +: 2] == 2'b01)) begin
            bad++;
            $error("FAIL mon_d_vld slice=%0d state=%0h vld=%0b", d_slice, d_thread_state, d_thread_vld);
         end
         if (d_idle !== (d_thread_state == 8'h00)) begin
            bad++;
            $error("FAIL mon_d_idle state=%0h idle=%0b", d_thread_state, d_idle);
         end
         if (t_thread_vld !== (t_thread_state[2*t_slice +: 2] == 2'b01)) begin
            bad++;
            $error("FAIL mon_t_vld slice=%0d state=%0h vld=%0b", t_slice, t_thread_state, t_thread_vld);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      exp_slice = exp_slice + 2'd1;
   endtask

   task automatic clear_inputs();
      wait_req = 1'b0; wait_thread = 2'd0; wait_done = 4'd0;
      halt_req = 1'b0; halt_thread = 2'd0;
      start_req = 1'b0; start_mask = 4'd0; irq = 4'd0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      step();
      rst = 1'b0;
      exp_slice = 2'd0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      @(posedge clk); #1;
      @(posedge clk); #1;

      `CHK("rst_slice", d_slice, 2'd0);
      `CHK("rst_state", d_thread_state, 8'h01);
      `CHK("rst_idle", d_idle, 1'b0);
      `CHK("rst_wake", {d_wake_vld, d_wake_thread, d_wake_irq}, 4'b0000);
      `CHK("rst_err", d_timeout_err, 4'b0000);
      `CHK("rst_to_state", t_thread_state, 8'h01);
      rst = 1'b0;
      exp_slice = 2'd0;

      for (int k = 0; k < 5; k++) begin
         `CHK("slice_seq", d_slice, exp_slice);
         `CHK("vld_seq", d_thread_vld, exp_slice == 2'd0);
         `CHK("idle_seq", d_idle, 1'b0);
         step();
      end

      wait_req = 1'b1; wait_thread = 2'd0; wait_done = 4'b0010;
      step();
      wait_req = 1'b0; wait_done = 4'd0;
      `CHK("wait_enter", d_thread_state[1:0], 2'b10);
      `CHK("wd_ignored", d_thread_state[3:2], 2'b00);
      for (int k = 0; k < 10; k++) begin
         step();
         `CHK("wait_hold", d_thread_state[1:0], 2'b10);
         `CHK("wait_vld", d_thread_vld, 1'b0);
      end
      wait_done = 4'b0001;
      step();
      wait_done = 4'd0;
      `CHK("wait_resume", d_thread_state[1:0], 2'b01);
      `CHK("wait_no_err", d_timeout_err, 4'b0000);
      `CHK("resume_no_wake", d_wake_vld, 1'b0);
      for (int k = 0; k < 4; k++) begin
         `CHK("vld_after_resume", d_thread_vld, exp_slice == 2'd0);
         step();
      end

      wait_req = 1'b1; wait_thread = 2'd0;
      step();
      wait_req = 1'b0;
      `CHK("pre_rst_wait", d_thread_state[1:0], 2'b10);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_slice = 2'd0;
      `CHK("rst_wait_state", d_thread_state, 8'h01);
      `CHK("rst_wait_slice", d_slice, 2'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         `CHK("rst_wait_nowake", d_wake_vld, 1'b0);
      end

      do_reset();
      wait_req = 1'b1; wait_thread = 2'd0;
      step();
      wait_req = 1'b0;
      for (int i = 1; i <= 13; i++) begin
         `CHK("to_wait", t_thread_state[1:0], 2'b10);
         `CHK("to_err_clr", t_timeout_err, 4'b0000);
         step();
      end
      `CHK("to_halt", t_thread_state[1:0], 2'b00);
      `CHK("to_err_set", t_timeout_err, 4'b0001);
      `CHK("to_idle", t_idle, 1'b1);
      `CHK("to_slice", t_slice, exp_slice);
      irq = 4'b0001;
      step();
      irq = 4'd0;
      `CHK("to_irq_run", t_thread_state[1:0], 2'b01);
      `CHK("to_irq_err_kept", t_timeout_err, 4'b0001);
      `CHK("to_irq_wake", {t_wake_vld, t_wake_thread, t_wake_irq}, 4'b1001);
      halt_req = 1'b1; halt_thread = 2'd0;
      step();
      halt_req = 1'b0;
      `CHK("to_rehalt", t_thread_state[1:0], 2'b00);
      start_req = 1'b1; start_mask = 4'b0001;
      step();
      start_req = 1'b0; start_mask = 4'd0;
      `CHK("to_start_run", t_thread_state[1:0], 2'b01);
      `CHK("to_start_clr", t_timeout_err, 4'b0000);
      `CHK("to_start_wake", {t_wake_vld, t_wake_thread, t_wake_irq}, 4'b1000);
      `CHK("to_thread_vld", t_thread_vld, exp_slice == 2'd0);
      step();
      `CHK("to_wake_once", t_wake_vld, 1'b0);
      start_req = 1'b1; start_mask = 4'b0001;
      step();
      start_req = 1'b0; start_mask = 4'd0;
      step();
      `CHK("start_on_run", {t_wake_vld, t_thread_state[1:0]}, 3'b001);

      do_reset();
      wait_req = 1'b1; wait_thread = 2'd0;
      step();
      wait_req = 1'b0;
      for (int i = 1; i < 10; i++) step();
      wait_req = 1'b1; wait_thread = 2'd0; wait_done = 4'b0001;
      step();
      wait_req = 1'b0; wait_done = 4'd0;
      for (int i = 11; i <= 21; i++) begin
         `CHK("rearm_wait", t_thread_state[1:0], 2'b10);
         step();
      end
      `CHK("rearm_halt", t_thread_state[1:0], 2'b00);
      `CHK("rearm_err", t_timeout_err, 4'b0001);

      do_reset();
      wait_req = 1'b1; wait_thread = 2'd0;
      step();
      wait_req = 1'b0;
      for (int i = 1; i < 13; i++) step();
      `CHK("edge_wait", t_thread_state[1:0], 2'b10);
      wait_done = 4'b0001;
      step();
      wait_done = 4'd0;
      `CHK("edge_resume", t_thread_state[1:0], 2'b01);
      `CHK("edge_no_err", t_timeout_err, 4'b0000);

      do_reset();
      halt_req = 1'b1; halt_thread = 2'd0;
      step();
      halt_req = 1'b0;
      `CHK("all_halt_idle", d_idle, 1'b1);
      `CHK("all_halt_state", d_thread_state, 8'h00);
      irq = 4'b1010;
      step();
      `CHK("irq_state", d_thread_state, 8'h44);
      `CHK("irq_idle", d_idle, 1'b0);
      `CHK("irq_wake1", {d_wake_vld, d_wake_thread, d_wake_irq}, 4'b1011);
      step();
      `CHK("irq_wake3", {d_wake_vld, d_wake_thread, d_wake_irq}, 4'b1111);
      step();
      `CHK("irq_wake_end", d_wake_vld, 1'b0);
      `CHK("irq_level_run", d_thread_state, 8'h44);
      for (int k = 0; k < 4; k++) begin
         `CHK("vld_13", d_thread_vld, (exp_slice == 2'd1) || (exp_slice == 2'd3));
         step();
      end
      irq = 4'd0;

      halt_req = 1'b1; halt_thread = 2'd1; irq = 4'b0010;
      step();
      halt_req = 1'b0;
      `CHK("halt_over_irq", d_thread_state[3:2], 2'b00);
      `CHK("halt_over_irq_nowake", d_wake_vld, 1'b0);
      step();
      irq = 4'd0;
      `CHK("irq_after_halt", d_thread_state[3:2], 2'b01);
      `CHK("irq_after_halt_wake", {d_wake_vld, d_wake_thread, d_wake_irq}, 4'b1011);

      start_req = 1'b1; start_mask = 4'b0100;
      step();
      start_req = 1'b0; start_mask = 4'd0;
      `CHK("start2_run", d_thread_state[5:4], 2'b01);
      `CHK("start2_wake", {d_wake_vld, d_wake_thread, d_wake_irq}, 4'b1100);
      halt_req = 1'b1; halt_thread = 2'd2; wait_req = 1'b1; wait_thread = 2'd2;
      step();
      halt_req = 1'b0; wait_req = 1'b0;
      `CHK("halt_over_wait", d_thread_state[5:4], 2'b00);
      `CHK("halt_over_wait_nowake", d_wake_vld, 1'b0);

      start_req = 1'b1; start_mask = 4'b0100; irq = 4'b0100;
      step();
      start_req = 1'b0; start_mask = 4'd0; irq = 4'd0;
      `CHK("start_irq_run", d_thread_state[5:4], 2'b01);
      `CHK("start_irq_wake", {d_wake_vld, d_wake_thread, d_wake_irq}, 4'b1101);
      step();
      `CHK("start_irq_single", d_wake_vld, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
